dmem_responder: RTL and testbench

- Data-memory responder serving the load/store requests issued by the pipeline's MEM stage; it is the memory end of the MEM-stage access interface.
- Accepts one request at a time over a valid/ready handshake and performs byte-enabled word writes or word reads.
- Returns exactly one response per accepted request after a fixed, parameterised latency; the requester has no back-pressure on responses.
- Flags misaligned and out-of-range accesses; a flagged access never modifies memory.

---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/dmem_bank.sv | 27 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared pipeline-wide types for the MEM-stage data-memory interface:
// responder state encoding, word geometry and the response-error code.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTE_LANES = 4;
  localparam int WORD_BYTES = 4;

  // Error code: one bit per cause, both may be set; zero means a clean access.
  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE     = 2'b00;
  localparam err_code_t ERR_MISALIGN = 2'b01;
  localparam err_code_t ERR_RANGE    = 2'b10;

  function automatic err_code_t classify(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span);
    logic [31:0] off;
    err_code_t   code;
    off  = addr - base;
    code = ERR_NONE;
    if (addr[1:0] != 2'b00) code = code | ERR_MISALIGN;
    if (off >= span)        code = code | ERR_RANGE;
    return code;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port; contents are not affected by any reset.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [BYTE_LANES-1:0]          we_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (we_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the MEM-stage access interface: one request at a time,
// one response per accepted request after LATENCY cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output state_t                dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready depends only on state, never on inputs.
  // resp_valid is a one-cycle pulse with no back-pressure.

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * WORD_BYTES);
  localparam bit          DIRECT    = (LATENCY == 1);
  localparam logic [3:0]  WAIT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [BYTE_LANES-1:0] be_q;
  logic                  err_q;
  logic                  load_q;

  logic                  accept;
  logic                  commit;
  logic                  c_we;
  logic [31:0]           c_addr;
  logic [31:0]           c_wdata;
  logic [BYTE_LANES-1:0] c_be;
  logic                  c_ok;
  logic [31:0]           c_off;
  logic [AW-1:0]         c_idx;
  logic [31:0]           bank_rdata;

  assign req_ready = (state != WAIT);
  assign accept    = req_valid && req_ready;

  // With LATENCY 1 the accepting edge is also the edge entering RESP, so the
  // bank must see the live request rather than the latched copy.
  assign commit  = !rst && (DIRECT ? accept : (state == WAIT && wait_cnt == 4'd0));
  assign c_we    = DIRECT ? req_we    : we_q;
  assign c_addr  = DIRECT ? req_addr  : addr_q;
  assign c_wdata = DIRECT ? req_wdata : wdata_q;
  assign c_be    = DIRECT ? req_be    : be_q;
  assign c_ok    = (classify(c_addr, BASE_ADDR, SPAN) == ERR_NONE);
  assign c_off   = c_addr - BASE_ADDR;
  assign c_idx   = AW'(c_off >> 2);

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .en    (commit),
    .we_be ((c_ok && c_we) ? c_be : '0),
    .idx   (c_idx),
    .wdata (c_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= '0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      err_q  <= commit && !c_ok;
      load_q <= commit && c_ok && !c_we;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (DIRECT) begin
              state <= RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = load_q ? bank_rdata : 32'd0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a default build (LATENCY 2) and a LATENCY 1 build
// checked every cycle against a word-level memory model plus literal values.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int W = 65; // {accept_cyc[15:0], due_cyc[15:0], err, rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  state_t      dbg_state [2];

  dmem_responder dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .dbg_state(dbg_state[0])
  );

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  bit comparing = 1'b0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [31:0]  mem_m [logic [32:0]];
  logic [31:0]  last_rdata [2];
  logic         last_err   [2];
  int           last_resp_cyc [2];
  int           last_issue_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level model: BASE 0, 256 words -> legal byte addresses 0..1023, aligned.
  function automatic logic [32:0] model_access(input int d, input logic we,
                                               input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input logic [3:0] be);
    logic [32:0] key;
    logic [31:0] word;
    if ((addr % 4) != 0 || addr >= 32'd1024) return {1'b1, 32'h0};
    key  = {d[0], addr};
    word = mem_m.exists(key) ? mem_m[key] : 32'h0;
    if (!we) return {1'b0, word};
    for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
    mem_m[key] = word;
    return {1'b0, 32'h0};
  endfunction

  task automatic cmp(input int d);
    logic [W-1:0] e;
    bit have;
    e    = '0;
    have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (have) e = (d == 0) ? exp_q0[0] : exp_q1[0];
    if (have && e[48:33] == 16'(cyc)) begin
      chk($sformatf("d%0d_resp_valid", d), 32'(resp_valid[d]), 32'd1);
      chk($sformatf("d%0d_resp_err", d),   32'(resp_err[d]),   32'(e[32]));
      chk($sformatf("d%0d_resp_rdata", d), resp_rdata[d],      e[31:0]);
      chk($sformatf("d%0d_ready_in_resp", d), 32'(req_ready[d]), 32'd1);
      last_rdata[d]    = resp_rdata[d];
      last_err[d]      = resp_err[d];
      last_resp_cyc[d] = cyc;
      if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
    end else begin
      chk($sformatf("d%0d_idle_valid", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("d%0d_idle_err", d),   32'(resp_err[d]),   32'd0);
      chk($sformatf("d%0d_idle_rdata", d), resp_rdata[d],      32'd0);
      chk($sformatf("d%0d_req_ready", d),  32'(req_ready[d]),
          (have && e[64:49] <= 16'(cyc) && e[48:33] > 16'(cyc)) ? 32'd0 : 32'd1);
    end
    if (d == 1) chk("d1_never_wait", 32'(dbg_state[1] == WAIT), 32'd0);
  endtask

  always @(negedge clk) begin
    if (comparing) begin
      cmp(0);
      cmp(1);
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is just after a falling edge. req_valid stays high on return so
  // consecutive calls form a back-to-back stream.
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit discard = 1'b0);
    int n;
    logic [32:0] r;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready[d]) begin
      chk($sformatf("d%0d_ready_timeout", d), 32'(req_ready[d]), 32'd1);
    end else begin
      r = discard ? 33'h0 : model_access(d, we, addr, wdata, be);
      last_issue_cyc = cyc;
      if (d == 0) exp_q0.push_back({16'(cyc + 1), 16'(cyc + 2), r});
      else        exp_q1.push_back({16'(cyc + 1), 16'(cyc + 1), r});
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int d);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) > 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk($sformatf("d%0d_drain", d), (d == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
  endtask

  task automatic single(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    issue(d, we, addr, wdata, be);
    idle(d);
    drain(d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0;
      last_rdata[d] = 32'h0; last_err[d] = 1'b0; last_resp_cyc[d] = 0;
    end
    last_issue_cyc = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_ready", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("d%0d_rst_valid", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("d%0d_rst_rdata", d), resp_rdata[d], 32'd0);
      chk($sformatf("d%0d_rst_err", d),   32'(resp_err[d]), 32'd0);
      chk($sformatf("d%0d_rst_state", d), 32'(dbg_state[d]), 32'(IDLE));
    end
    #1 rst = 1'b0;
    comparing = 1'b1;
    @(negedge clk); #1;

    // Full store then load, LATENCY 2
    single(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("store_latency", 32'(last_resp_cyc[0] - last_issue_cyc), 32'd2);
    chk("store_err", 32'(last_err[0]), 32'd0);
    chk("store_rdata", last_rdata[0], 32'd0);
    single(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("load_full", last_rdata[0], 32'hDEADBEEF);

    // Partial store
    single(0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
    single(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("load_partial", last_rdata[0], 32'hDE22BE44);

    // Seed words for the stream and reset tests
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 32'(4 * i), 32'hA0A00000 + 32'(4 * i), 4'hF);
    issue(0, 1'b1, 32'h20, 32'h01020304, 4'hF);
    idle(0);
    drain(0);

    // Back-to-back loads with req_valid held high
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'(4 * i), 32'h0, 4'h0);
    idle(0);
    drain(0);
    chk("b2b_last_data", last_rdata[0], 32'hA0A0000C);

    // Errors and the zero-enable store
    single(0, 1'b0, 32'h12, 32'h0, 4'h0);
    chk("misaligned_err", 32'(last_err[0]), 32'd1);
    chk("misaligned_rdata", last_rdata[0], 32'd0);
    single(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
    chk("range_err", 32'(last_err[0]), 32'd1);
    single(0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("range_no_write", last_rdata[0], 32'hA0A00000);
    single(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
    single(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("misaligned_no_write", last_rdata[0], 32'hDE22BE44);
    single(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0);
    chk("be0_err", 32'(last_err[0]), 32'd0);
    single(0, 1'b0, 32'h4, 32'h0, 4'h0);
    chk("be0_no_change", last_rdata[0], 32'hA0A00004);
    single(0, 1'b0, 32'h3FC, 32'h0, 4'h0);
    chk("top_word_err", 32'(last_err[0]), 32'd0);

    // LATENCY 1 build: store followed immediately by loads, one per cycle
    issue(1, 1'b1, 32'h8, 32'h55AA55AA, 4'hF);
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0);
    chk("l1_latency", 32'(last_resp_cyc[1] - last_issue_cyc), 32'd1);
    chk("l1_store_then_load", last_rdata[1], 32'h55AA55AA);
    issue(1, 1'b1, 32'hC, 32'h12345678, 4'b1100);
    issue(1, 1'b0, 32'hC, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h3FF, 32'h0, 4'h0);
    idle(1);
    drain(1);
    chk("l1_err_tail", 32'(last_err[1]), 32'd1);

    // Reset while a store is waiting
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    rst = 1'b1;
    req_valid[0] = 1'b0;
    exp_q0.delete();
    @(negedge clk); #1;
    chk("midrst_ready", 32'(req_ready[0]), 32'd1);
    rst = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    single(0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("midrst_no_commit", last_rdata[0], 32'h01020304);

    repeat (2) begin @(negedge clk); #1; end
    comparing = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
